// File: rtl/switch_monitor_display.sv
// -----------------------------------------------------------------------------
// switch_monitor_display
//
// Board-level switch monitor. Each of CHANNELS slide switches is synchronised,
// debounced and shown on its own LED and 7-segment digit. The digit shows
// either the debounced switch state (0/1) or a 4-bit count of accepted
// changes in hex. The decimal point lights for FLASH_CYCLES after every
// accepted change.
//
// Ports
//   clock  in   system clock
//   reset  in   synchronous, active-high reset
//   SW     in   [0:CHANNELS-1]    raw asynchronous switches, 1 = up
//   MODE   in   0 = show state, 1 = show toggle count
//   CLEAR  in   synchronous clear of all toggle counts
//   LEDR   out  [0:CHANNELS-1]    debounced switch state, 1 = lit
//   HEX    out  [0:8*CHANNELS-1]  digit i = HEX[8*i +: 8], active-low,
//                                 slice MSB = DP, remaining bits = g..a
// -----------------------------------------------------------------------------
module switch_monitor_display #(
  parameter int CHANNELS        = 6,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FLASH_CYCLES    = 12500000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [0:CHANNELS-1]   SW,
  input  logic                  MODE,
  input  logic                  CLEAR,
  output logic [0:CHANNELS-1]   LEDR,
  output logic [0:8*CHANNELS-1] HEX
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int FL_W  = $clog2(FLASH_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [FL_W-1:0]  FL_LOAD  = FL_W'(FLASH_CYCLES);

  // Two-stage synchroniser, debounced state and change strobe.
  logic [0:CHANNELS-1] s1_q, s2_q;
  logic [0:CHANNELS-1] st_q, st_d;
  logic [0:CHANNELS-1] chg;

  logic [CNT_W-1:0] cnt_q [CHANNELS];
  logic [CNT_W-1:0] cnt_d [CHANNELS];
  logic [3:0]       tc_q  [CHANNELS];
  logic [3:0]       tc_d  [CHANNELS];
  logic [FL_W-1:0]  fl_q  [CHANNELS];
  logic [FL_W-1:0]  fl_d  [CHANNELS];
  logic [7:0]       hex_q [CHANNELS];
  logic [7:0]       hex_d [CHANNELS];

  // Active-low segment pattern with the decimal point dark.
  function automatic logic [7:0] seg_code(input logic [3:0] v);
    logic [7:0] code;
    unique case (v)
      4'h0: code = 8'hC0;
      4'h1: code = 8'hF9;
      4'h2: code = 8'hA4;
      4'h3: code = 8'hB0;
      4'h4: code = 8'h99;
      4'h5: code = 8'h92;
      4'h6: code = 8'h82;
      4'h7: code = 8'hF8;
      4'h8: code = 8'h80;
      4'h9: code = 8'h90;
      4'hA: code = 8'h88;
      4'hB: code = 8'h83;
      4'hC: code = 8'hC6;
      4'hD: code = 8'hA1;
      4'hE: code = 8'h86;
      default: code = 8'h8E;
    endcase
    return code;
  endfunction

  always_comb begin
    // NOTE: every signal driven here gets a value on every path through the
    // block; a missing default would silently infer a latch.
    st_d = st_q;
    chg  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      // Debounce: count consecutive cycles disagreeing with the stable value;
      // any agreeing cycle restarts the count.
      cnt_d[i] = '0;
      if (s2_q[i] != st_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          st_d[i] = s2_q[i];
          chg[i]  = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end

      // CLEAR has priority over a simultaneous change.
      if (CLEAR) begin
        tc_d[i] = '0;
      end else if (chg[i]) begin
        tc_d[i] = tc_q[i] + 1'b1;
      end else begin
        tc_d[i] = tc_q[i];
      end

      // A new change restarts a flash already in progress.
      if (chg[i]) begin
        fl_d[i] = FL_LOAD;
      end else if (fl_q[i] != '0) begin
        fl_d[i] = fl_q[i] - 1'b1;
      end else begin
        fl_d[i] = fl_q[i];
      end

      hex_d[i] = seg_code(MODE ? tc_q[i] : {3'b000, st_q[i]});
      if (fl_q[i] != '0) begin
        hex_d[i][7] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: per-channel arrays here are plain flops, not RAM, so they are
    // reset like any other register.
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
      st_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
        tc_q[i]  <= '0;
        fl_q[i]  <= '0;
        hex_q[i] <= 8'hC0;
      end
    end else begin
      // NOTE: non-blocking assignments so s2_q takes the old s1_q value and
      // the synchroniser really is two stages.
      s1_q <= SW;
      s2_q <= s1_q;
      st_q <= st_d;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
        tc_q[i]  <= tc_d[i];
        fl_q[i]  <= fl_d[i];
        hex_q[i] <= hex_d[i];
      end
    end
  end

  assign LEDR = st_q;

  always_comb begin
    HEX = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      HEX[8*i +: 8] = hex_q[i];
    end
  end

endmodule

// File: tb/tb_switch_monitor_display.sv
// -----------------------------------------------------------------------------
// tb_switch_monitor_display
//
// Directed bench for switch_monitor_display with DEBOUNCE_CYCLES=4,
// FLASH_CYCLES=8, CHANNELS=6. A behavioural model tracks each channel as a
// history window of sampled switch values plus the time of the last accepted
// change; every cycle all LEDs and digits are compared against it. Hand-computed
// literals at key points pin the model itself.
// -----------------------------------------------------------------------------
module tb_switch_monitor_display;

  localparam int CH = 6;
  localparam int D  = 4;
  localparam int F  = 8;

  localparam logic [7:0] SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [0:CH-1]    SW    = '0;
  logic             MODE  = 1'b0;
  logic             CLEAR = 1'b0;
  logic [0:CH-1]    LEDR;
  logic [0:8*CH-1]  HEX;

  int n_checks = 0;
  int n_fail   = 0;

  switch_monitor_display #(
    .CHANNELS        (CH),
    .DEBOUNCE_CYCLES (D),
    .FLASH_CYCLES    (F)
  ) dut (
    .clock (clock),
    .reset (reset),
    .SW    (SW),
    .MODE  (MODE),
    .CLEAR (CLEAR),
    .LEDR  (LEDR),
    .HEX   (HEX)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] slice(input int ch);
    return HEX[8*ch +: 8];
  endfunction

  // ---------------------------------------------------------------------------
  // Model. samp holds the switch value sampled at each of the last D+1 edges
  // (bit 0 newest). Because of the two synchroniser stages, the debouncer at a
  // given edge sees the sample from two edges earlier; a change is accepted
  // when the D most recent such samples all differ from the stable value.
  // ---------------------------------------------------------------------------
  logic [D:0] m_samp [CH];
  logic       m_st   [CH];
  int         m_tc   [CH];
  int         m_last [CH];   // edge index of last accepted change, -1 = none
  logic [7:0] m_hex  [CH];
  int         cyc     = 0;
  bit         m_valid = 1'b0;

  function automatic bit accepts(input logic [D:0] samp, input logic st);
    return samp[D:1] == {D{~st}};
  endfunction

  function automatic logic [7:0] expect_hex(input int val, input bit lit);
    logic [7:0] s;
    s = SEG[val];
    return lit ? {1'b0, s[6:0]} : s;
  endfunction

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset) begin
      m_valid <= 1'b1;
      for (int ch = 0; ch < CH; ch++) begin
        m_samp[ch] <= '0;
        m_st[ch]   <= 1'b0;
        m_tc[ch]   <= 0;
        m_last[ch] <= -1;
        m_hex[ch]  <= 8'hC0;
      end
    end else begin
      for (int ch = 0; ch < CH; ch++) begin
        m_samp[ch] <= {m_samp[ch][D-1:0], SW[ch]};
        if (accepts(m_samp[ch], m_st[ch])) begin
          m_st[ch]   <= ~m_st[ch];
          m_last[ch] <= cyc;
        end
        m_tc[ch] <= CLEAR ? 0 :
                    accepts(m_samp[ch], m_st[ch]) ? (m_tc[ch] + 1) % 16 : m_tc[ch];
        // Display reflects state after the previous edge; DP lit for F
        // display cycles following an accepted change.
        m_hex[ch] <= expect_hex(MODE ? m_tc[ch] : int'(m_st[ch]),
                                (m_last[ch] >= 0) && ((cyc - 1 - m_last[ch]) < F));
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (m_valid) begin
      for (int ch = 0; ch < CH; ch++) begin
        check($sformatf("model LEDR[%0d]", ch), 32'(LEDR[ch]), 32'(m_st[ch]));
        check($sformatf("model HEX slice %0d", ch), 32'(slice(ch)), 32'(m_hex[ch]));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus; inputs change 1 time unit after an edge, so an input
  // applied after edge k is first sampled at edge k+1.
  // ---------------------------------------------------------------------------
  initial begin
    // 1: reset with switches low
    step();
    step();
    check("reset LEDR", 32'(LEDR), 32'h0);
    check("reset slice0", 32'(slice(0)), 32'hC0);
    check("reset slice5", 32'(slice(5)), 32'hC0);
    reset = 1'b0;
    repeat (10) step();
    check("idle LEDR", 32'(LEDR), 32'h0);
    check("idle slice3", 32'(slice(3)), 32'hC0);

    // 2: SW[0] rises after edge k
    SW[0] = 1'b1;
    repeat (5) step();
    check("sw0 k+5 LEDR0", 32'(LEDR[0]), 32'h0);
    step();
    check("sw0 k+6 LEDR0", 32'(LEDR[0]), 32'h1);
    check("sw0 k+6 slice0", 32'(slice(0)), 32'hC0);
    step();
    check("sw0 k+7 slice0", 32'(slice(0)), 32'h79);
    repeat (7) step();
    check("sw0 k+14 slice0", 32'(slice(0)), 32'h79);
    step();
    check("sw0 k+15 slice0", 32'(slice(0)), 32'hF9);

    // 3: short glitches on SW[2] are rejected
    SW[2] = 1'b1;
    step();
    SW[2] = 1'b0;
    repeat (8) step();
    SW[2] = 1'b1;
    repeat (3) step();
    SW[2] = 1'b0;
    repeat (12) step();
    check("glitch LEDR2", 32'(LEDR[2]), 32'h0);
    check("glitch slice2", 32'(slice(2)), 32'hC0);

    // 4: count mode, 17 toggles of SW[1]
    MODE = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      SW[1] = ~SW[1];
      repeat (10) step();
      if (i == 15) check("toggle 15 slice1", 32'(slice(1)), 32'h0E);
      if (i == 16) check("toggle 16 slice1", 32'(slice(1)), 32'h40);
      if (i == 17) check("toggle 17 slice1", 32'(slice(1)), 32'h79);
    end
    repeat (10) step();
    check("toggle end slice1", 32'(slice(1)), 32'hF9);
    check("toggle end LEDR1", 32'(LEDR[1]), 32'h1);
    check("count mode slice0", 32'(slice(0)), 32'hF9);

    // 5: CLEAR coincides with the change on SW[3]
    SW[3] = 1'b1;
    repeat (5) step();
    CLEAR = 1'b1;
    step();
    CLEAR = 1'b0;
    check("clear LEDR3", 32'(LEDR[3]), 32'h1);
    step();
    check("clear flash slice3", 32'(slice(3)), 32'h40);
    check("clear slice1", 32'(slice(1)), 32'hC0);
    repeat (8) step();
    check("clear end slice3", 32'(slice(3)), 32'hC0);

    // 6: reset in the middle of debouncing SW[4]
    SW[4] = 1'b1;
    repeat (3) step();
    reset = 1'b1;
    step();
    check("midreset LEDR", 32'(LEDR), 32'h0);
    check("midreset slice4", 32'(slice(4)), 32'hC0);
    step();
    reset = 1'b0;
    repeat (5) step();
    check("post reset r+5 LEDR4", 32'(LEDR[4]), 32'h0);
    step();
    check("post reset r+6 LEDR", 32'(LEDR), 32'(6'b110110));
    step();
    check("post reset slice4", 32'(slice(4)), 32'h79);
    repeat (8) step();
    check("post reset end slice4", 32'(slice(4)), 32'hF9);
    check("post reset end slice3", 32'(slice(3)), 32'hF9);

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
